// File: rtl/seq_div32x16_pkg.sv
// Shared arithmetic-datapath definitions for the sequential divider and the
// multiplier verification model.
package seq_div32x16_pkg;

    localparam int unsigned W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

    localparam logic [W_DEF-1:0] Q_POS_SAT = 16'h7FFF;
    localparam logic [W_DEF-1:0] Q_NEG_SAT = 16'h8000;

    // Callers sign-extend into 64 bits and truncate the result back down.
    function automatic logic [63:0] abs_mag(input logic [63:0] x);
        return x[63] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/seq_div32x16_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor magnitude, and shift the resulting quotient bit into dvd.
module seq_div32x16_div_step
    import seq_div32x16_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0]   rem_i,
    input  logic [2*W-1:0] dvd_i,
    input  logic [W-1:0]   dsr_i,
    output logic [W-1:0]   rem_o,
    output logic [2*W-1:0] dvd_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem < dsr <= 2^(W-1), so the shifted value fits W+1 bits and trial[W] is its sign.
    always_comb begin
        shifted = {rem_i, dvd_i[2*W-1]};
        trial   = shifted - {1'b0, dsr_i};
        if (trial[W]) begin
            rem_o = shifted[W-1:0];
            dvd_o = {dvd_i[2*W-2:0], 1'b0};
        end else begin
            rem_o = trial[W-1:0];
            dvd_o = {dvd_i[2*W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div32x16.sv
// Iterative signed 2W/W divider: restoring division on magnitudes, one quotient
// bit per clock, then sign correction with overflow saturation and divide-by-zero.
module seq_div32x16
    import seq_div32x16_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           ovf,
    output logic           dbz
);

    localparam int unsigned    CW    = $clog2(2 * W);
    localparam logic [2*W-1:0] Q_LIM = (2 * W)'(1) << (W - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [2*W-1:0] dvd_q, dvd_d;
    logic [W-1:0]   dsr_q, dsr_d;
    logic           sign_q_q, sign_q_d;
    logic           sign_r_q, sign_r_d;
    logic           dbz_pend_q, dbz_pend_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic           done_q, done_d;

    logic [W-1:0]   step_rem;
    logic [2*W-1:0] step_dvd;
    logic           q_ovf;

    seq_div32x16_div_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    // -2^(W-1) is a legal negative quotient, so the negative limit is inclusive.
    assign q_ovf = sign_q_q ? (dvd_q > Q_LIM) : (dvd_q >= Q_LIM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        dbz_pend_d  = dbz_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d    = SIGN;
                        dbz_pend_d = 1'b1;
                        rem_d      = dividend[W-1:0];
                    end else begin
                        state_d    = CALC;
                        dbz_pend_d = 1'b0;
                        dvd_d      = (2 * W)'(abs_mag(64'(signed'(dividend))));
                        dsr_d      = W'(abs_mag(64'(signed'(divisor))));
                        sign_q_d   = dividend[2*W-1] ^ divisor[W-1];
                        sign_r_d   = dividend[2*W-1];
                        rem_d      = '0;
                        cnt_d      = CW'(2 * W - 1);
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SIGN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dbz_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = rem_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else begin
                    dbz_d = 1'b0;
                    ovf_d = q_ovf;
                    if (q_ovf) begin
                        quotient_d  = sign_q_q ? Q_NEG_SAT : Q_POS_SAT;
                        remainder_d = '0;
                    end else begin
                        quotient_d  = sign_q_q ? (W'(0) - dvd_q[W-1:0]) : dvd_q[W-1:0];
                        remainder_d = sign_r_q ? (W'(0) - rem_q) : rem_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            dbz_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            dbz_pend_q  <= dbz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
